// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI slave engine.
//   spi_state_e  - engine state (IDLE, LOAD, SHIFT)
//   spi_mode_t   - clock polarity / phase pair latched at the start of a frame
//   SPI_DEFAULT_DATA_WIDTH - default bits per SPI word
package spi_pkg;

    localparam int unsigned SPI_DEFAULT_DATA_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2
    } spi_state_e;

    typedef struct packed {
        logic cpol;
        logic cpha;
    } spi_mode_t;

endpackage

// File: rtl/spi_pin_sync.sv
// Two-flop synchronizer plus one history flop for an asynchronous SPI pin.
// Ports:
//   pclk, areset - system clock, synchronous active-high reset
//   pin          - asynchronous input pin
//   level        - synchronized pin level
//   rise, fall   - single-cycle strobes on a synchronized transition
module spi_pin_sync #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic pclk,
    input  logic areset,
    input  logic pin,
    output logic level,
    output logic rise,
    output logic fall
);

    logic meta;
    logic sync;
    logic hist;

    always_ff @(posedge pclk) begin
        if (areset) begin
            meta <= RESET_VAL;
            sync <= RESET_VAL;
            hist <= RESET_VAL;
        end else begin
            meta <= pin;
            sync <= meta;
            hist <= sync;
        end
    end

    assign level = sync;
    assign rise  = sync & ~hist;
    assign fall  = ~sync & hist;

endmodule

// File: rtl/spi_slave_core.sv
// SPI slave engine: oversamples sclk/cs/mosi on pclk, drives miso, exchanges
// parallel words with a local tx/rx interface and publishes a monitor record
// (MOSI and MISO word) for every completed transfer.
// Ports:
//   pclk, areset            - system clock, synchronous active-high reset
//   cpol, cpha              - SPI mode, latched when a frame starts
//   sclk, cs, mosi          - asynchronous SPI pins (cs active low)
//   miso, miso_oe           - slave data out and its output enable
//   tx_data/tx_valid/tx_ready - one-entry transmit holding register handshake
//   rx_data, rx_valid       - last received word and its update pulse
//   mon_mosi/mon_miso/mon_valid - monitor record of the completed word
//   underrun                - a word was started with no data available
//   frame_err, err_bits     - cs rose mid-word, with the bits received so far
module spi_slave_core
    import spi_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = SPI_DEFAULT_DATA_WIDTH,
    parameter bit          MSB_FIRST  = 1'b1
) (
    input  logic                            pclk,
    input  logic                            areset,
    input  logic                            cpol,
    input  logic                            cpha,
    input  logic                            sclk,
    input  logic                            cs,
    input  logic                            mosi,
    output logic                            miso,
    output logic                            miso_oe,
    input  logic [DATA_WIDTH-1:0]           tx_data,
    input  logic                            tx_valid,
    output logic                            tx_ready,
    output logic [DATA_WIDTH-1:0]           rx_data,
    output logic                            rx_valid,
    output logic [DATA_WIDTH-1:0]           mon_mosi,
    output logic [DATA_WIDTH-1:0]           mon_miso,
    output logic                            mon_valid,
    output logic                            underrun,
    output logic                            frame_err,
    output logic [$clog2(DATA_WIDTH+1)-1:0] err_bits
);

    localparam int unsigned   CW        = $clog2(DATA_WIDTH + 1);
    localparam int unsigned   IW        = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0] LAST_BIT  = CW'(DATA_WIDTH - 1);
    localparam logic [CW-1:0] WORD_BITS = CW'(DATA_WIDTH);

    logic sclk_rise, sclk_fall, cs_rise, cs_fall, mosi_lvl;
    logic sclk_level_unused, cs_level_unused, mosi_rise_unused, mosi_fall_unused;

    spi_pin_sync #(.RESET_VAL(1'b0)) u_sync_sclk (
        .pclk(pclk), .areset(areset), .pin(sclk),
        .level(sclk_level_unused), .rise(sclk_rise), .fall(sclk_fall)
    );

    spi_pin_sync #(.RESET_VAL(1'b1)) u_sync_cs (
        .pclk(pclk), .areset(areset), .pin(cs),
        .level(cs_level_unused), .rise(cs_rise), .fall(cs_fall)
    );

    spi_pin_sync #(.RESET_VAL(1'b0)) u_sync_mosi (
        .pclk(pclk), .areset(areset), .pin(mosi),
        .level(mosi_lvl), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
    );

    spi_state_e              state, next_state;
    spi_mode_t               mode;
    logic [DATA_WIDTH-1:0]   hold_data;
    logic                    hold_full;
    logic [DATA_WIDTH-1:0]   tx_word;
    logic [DATA_WIDTH-1:0]   rx_sr;
    logic [DATA_WIDTH-1:0]   rx_next;
    logic [DATA_WIDTH-1:0]   load_word;
    logic [CW-1:0]           bit_cnt;
    logic [CW-1:0]           cnt_after;
    logic [CW-1:0]           out_idx;
    logic                    under_pend;
    logic                    lead_edge, trail_edge, sample_edge, shift_edge;
    logic                    accept;
    logic                    first_load, word_load, word_done, abort;

    function automatic logic tx_bit(input logic [DATA_WIDTH-1:0] w,
                                    input logic [CW-1:0] idx);
        logic [IW-1:0] pos;
        pos = idx[IW-1:0];
        if (MSB_FIRST)
            pos = IW'(DATA_WIDTH - 1) - pos;
        return w[pos];
    endfunction

    assign lead_edge   = mode.cpol ? sclk_fall : sclk_rise;
    assign trail_edge  = mode.cpol ? sclk_rise : sclk_fall;
    assign sample_edge = mode.cpha ? trail_edge : lead_edge;
    assign shift_edge  = mode.cpha ? lead_edge  : trail_edge;

    assign tx_ready  = ~hold_full;
    assign accept    = tx_valid & ~hold_full;
    assign load_word = hold_full ? hold_data : '1;
    assign cnt_after = bit_cnt + {{(CW-1){1'b0}}, sample_edge};

    always_comb begin
        if (MSB_FIRST)
            rx_next = {rx_sr[DATA_WIDTH-2:0], mosi_lvl};
        else
            rx_next = {mosi_lvl, rx_sr[DATA_WIDTH-1:1]};
    end

    always_ff @(posedge pclk) begin
        if (areset)
            state <= IDLE;
        else
            state <= next_state;
    end

    // The holding-register transfer is done on the edge that enters LOAD so
    // that the first bit is already on miso for the whole LOAD cycle.
    always_comb begin
        next_state = state;
        first_load = 1'b0;
        word_load  = 1'b0;
        word_done  = 1'b0;
        abort      = 1'b0;
        unique case (state)
            IDLE: begin
                if (cs_fall) begin
                    next_state = LOAD;
                    first_load = 1'b1;
                end
            end
            LOAD: begin
                next_state = cs_rise ? IDLE : SHIFT;
            end
            SHIFT: begin
                if (sample_edge && bit_cnt == LAST_BIT) begin
                    word_done = 1'b1;
                    if (cs_rise)
                        next_state = IDLE;
                    else
                        word_load = 1'b1;
                end else if (cs_rise) begin
                    next_state = IDLE;
                    abort      = (cnt_after != '0);
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge pclk) begin
        if (areset) begin
            mode       <= '0;
            hold_data  <= '0;
            hold_full  <= 1'b0;
            tx_word    <= '0;
            rx_sr      <= '0;
            bit_cnt    <= '0;
            out_idx    <= '0;
            under_pend <= 1'b0;
            miso       <= 1'b0;
            miso_oe    <= 1'b0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            mon_mosi   <= '0;
            mon_miso   <= '0;
            mon_valid  <= 1'b0;
            underrun   <= 1'b0;
            frame_err  <= 1'b0;
            err_bits   <= '0;
        end else begin
            rx_valid  <= 1'b0;
            mon_valid <= 1'b0;
            underrun  <= 1'b0;
            frame_err <= 1'b0;

            if (accept)
                hold_data <= tx_data;
            hold_full <= (hold_full & ~(first_load | word_load)) | accept;

            if (first_load) begin
                mode.cpol  <= cpol;
                mode.cpha  <= cpha;
                tx_word    <= load_word;
                miso       <= tx_bit(load_word, '0);
                out_idx    <= cpha ? '0 : {{(CW-1){1'b0}}, 1'b1};
                miso_oe    <= 1'b1;
                bit_cnt    <= '0;
                under_pend <= 1'b0;
                underrun   <= ~hold_full;
            end

            if (state == SHIFT) begin
                if (sample_edge) begin
                    rx_sr   <= rx_next;
                    bit_cnt <= bit_cnt + 1'b1;
                    // A back-to-back reload that found no data only counts as
                    // an underrun once the master actually clocks that word;
                    // a frame ending right after its last word never reports one.
                    if (bit_cnt == '0 && under_pend) begin
                        underrun   <= 1'b1;
                        under_pend <= 1'b0;
                    end
                end
                if (shift_edge && out_idx < WORD_BITS) begin
                    miso    <= tx_bit(tx_word, out_idx);
                    out_idx <= out_idx + 1'b1;
                end
                if (word_done) begin
                    rx_data   <= rx_next;
                    mon_mosi  <= rx_next;
                    mon_miso  <= tx_word;
                    rx_valid  <= 1'b1;
                    mon_valid <= 1'b1;
                    bit_cnt   <= '0;
                end
                if (word_load) begin
                    tx_word    <= load_word;
                    out_idx    <= '0;
                    under_pend <= ~hold_full;
                end
            end

            if (state != IDLE && next_state == IDLE) begin
                miso       <= 1'b0;
                miso_oe    <= 1'b0;
                under_pend <= 1'b0;
            end

            if (abort) begin
                frame_err <= 1'b1;
                err_bits  <= cnt_after;
            end
        end
    end

endmodule

// File: tb/tb_spi_slave_core.sv
// Self-checking bench for spi_slave_core: an SPI master model drives frames,
// a reference model predicts the exchanged words, and a monitor process
// compares every rx_valid / frame_err event against the scoreboard queues.
module tb_spi_slave_core;

    localparam int DW  = 8;
    localparam int H   = 4;       // sclk half period in pclk cycles
    localparam int PER = 10;      // pclk period in time units

    logic       pclk = 1'b0;
    logic       areset = 1'b1;
    logic       cpol = 1'b0, cpha = 1'b0, sclk = 1'b0, cs = 1'b1, mosi = 1'b0;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_data = '0;
    logic       miso, miso_oe, tx_ready, rx_valid, mon_valid, underrun, frame_err;
    logic [7:0] rx_data, mon_mosi, mon_miso;
    logic [3:0] err_bits;

    spi_slave_core #(.DATA_WIDTH(DW), .MSB_FIRST(1'b1)) dut (
        .pclk(pclk), .areset(areset), .cpol(cpol), .cpha(cpha),
        .sclk(sclk), .cs(cs), .mosi(mosi), .miso(miso), .miso_oe(miso_oe),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid),
        .mon_mosi(mon_mosi), .mon_miso(mon_miso), .mon_valid(mon_valid),
        .underrun(underrun), .frame_err(frame_err), .err_bits(err_bits)
    );

    always #(PER/2) pclk = ~pclk;

    typedef struct {
        logic [7:0] mosi_w;
        logic [7:0] miso_w;
    } word_rec_t;

    int unsigned n_checks = 0, n_pass = 0;
    word_rec_t   exp_q[$];
    int unsigned err_q[$];
    logic [7:0]  tx_model_q[$];
    int unsigned exp_underruns = 0, seen_underruns = 0;
    time         last_sample_t = 0;
    word_rec_t   mon_rec;
    logic [7:0]  f_mosi[3];
    logic [7:0]  f_tx[3];
    bit          f_push[3];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a result.
    always @(negedge pclk) begin
        if (!areset) begin
            if (underrun) seen_underruns++;
            if (rx_valid || mon_valid) begin
                if (exp_q.size() == 0) begin
                    chk("rx_valid_spurious", {31'd0, rx_valid}, 32'd0);
                end else begin
                    mon_rec = exp_q.pop_front();
                    chk("rx_data",   {24'd0, rx_data},  {24'd0, mon_rec.mosi_w});
                    chk("mon_mosi",  {24'd0, mon_mosi}, {24'd0, mon_rec.mosi_w});
                    chk("mon_miso",  {24'd0, mon_miso}, {24'd0, mon_rec.miso_w});
                    chk("rx_valid",  {31'd0, rx_valid},  32'd1);
                    chk("mon_valid", {31'd0, mon_valid}, 32'd1);
                    chk("rx_latency", 32'($time - last_sample_t), 32'(3 * PER));
                end
            end
            if (frame_err) begin
                if (err_q.size() == 0) begin
                    chk("frame_err_spurious", {31'd0, frame_err}, 32'd0);
                end else begin
                    chk("err_bits", {28'd0, err_bits}, err_q.pop_front());
                end
            end
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge pclk);
    endtask

    task automatic push_tx(input logic [7:0] w);
        int unsigned t = 0;
        while (!tx_ready && t < 50) begin
            @(negedge pclk);
            t++;
        end
        if (!tx_ready) chk("tx_ready_timeout", {31'd0, tx_ready}, 32'd1);
        tx_data  = w;
        tx_valid = 1'b1;
        @(negedge pclk);
        tx_valid = 1'b0;
        tx_model_q.push_back(w);
    endtask

    // Reference model: each started word takes the oldest offered tx word,
    // or all-ones (an underrun) when none was offered.
    function automatic logic [7:0] model_next_tx();
        if (tx_model_q.size() == 0) begin
            exp_underruns++;
            return 8'hFF;
        end
        return tx_model_q.pop_front();
    endfunction

    task automatic xfer(input logic cp, input logic ch, input logic [7:0] mw,
                        input int nbits, output logic [7:0] rw);
        rw = '0;
        for (int i = 0; i < nbits; i++) begin
            if (!ch) begin
                mosi = mw[7-i];
                wait_cyc(H);
                sclk = ~cp;
                rw = {rw[6:0], miso};
                last_sample_t = $time;
                wait_cyc(H);
                sclk = cp;
            end else begin
                wait_cyc(H);
                sclk = ~cp;
                mosi = mw[7-i];
                wait_cyc(H);
                sclk = cp;
                rw = {rw[6:0], miso};
                last_sample_t = $time;
            end
        end
    endtask

    task automatic frame_begin(input logic cp, input logic ch);
        cpol = cp;
        cpha = ch;
        sclk = cp;
        wait_cyc(6);
        cs = 1'b0;
        wait_cyc(4);
        chk("miso_oe_after_cs_fall", {31'd0, miso_oe}, 32'd1);
        wait_cyc(2);
    endtask

    task automatic frame_end();
        wait_cyc(H);
        cs = 1'b1;
        wait_cyc(4);
        chk("miso_oe_after_cs_rise", {31'd0, miso_oe}, 32'd0);
        chk("miso_idle", {31'd0, miso}, 32'd0);
    endtask

    task automatic run_frame(input logic cp, input logic ch, input int nw);
        logic [7:0] exp_miso, got;
        word_rec_t  r;
        if (f_push[0]) push_tx(f_tx[0]);
        frame_begin(cp, ch);
        for (int k = 0; k < nw; k++) begin
            if (k > 0) wait_cyc(4);
            exp_miso = model_next_tx();
            if (k + 1 < nw && f_push[k+1]) push_tx(f_tx[k+1]);
            r.mosi_w = f_mosi[k];
            r.miso_w = exp_miso;
            exp_q.push_back(r);
            xfer(cp, ch, f_mosi[k], DW, got);
            chk("master_rx", {24'd0, got}, {24'd0, exp_miso});
        end
        frame_end();
    endtask

    initial begin
        #(50000 * PER);
        $display("FAIL watchdog: bench did not complete in time");
        $fatal(1);
    end

    initial begin
        logic [7:0]  got;
        int unsigned u0;

        areset = 1'b1;
        wait_cyc(4);
        areset = 1'b0;
        wait_cyc(2);
        chk("reset_tx_ready", {31'd0, tx_ready}, 32'd1);
        chk("reset_miso_oe",  {31'd0, miso_oe},  32'd0);
        chk("reset_miso",     {31'd0, miso},     32'd0);
        chk("reset_rx_data",  {24'd0, rx_data},  32'd0);
        chk("reset_mon_miso", {24'd0, mon_miso}, 32'd0);

        // Mode 0: preloaded 0xA5, master sends 0x3C
        f_mosi[0] = 8'h3C; f_tx[0] = 8'hA5; f_push[0] = 1'b1;
        run_frame(1'b0, 1'b0, 1);

        // Mode 3: preloaded 0x5A, master sends 0xC3
        f_mosi[0] = 8'hC3; f_tx[0] = 8'h5A; f_push[0] = 1'b1;
        run_frame(1'b1, 1'b1, 1);

        // Underrun: nothing offered before cs falls
        u0 = seen_underruns;
        f_mosi[0] = 8'h66; f_push[0] = 1'b0;
        run_frame(1'b0, 1'b0, 1);
        wait_cyc(4);
        chk("underrun_once", seen_underruns - u0, 32'd1);

        // Abort after 5 sclk cycles
        push_tx(8'h96);
        frame_begin(1'b0, 1'b0);
        void'(model_next_tx());
        xfer(1'b0, 1'b0, 8'hB7, 5, got);
        err_q.push_back(5);
        frame_end();
        chk("rx_data_after_abort", {24'd0, rx_data}, 32'h66);

        // Back-to-back words with cs held low
        f_mosi[0] = 8'hAB; f_tx[0] = 8'h12; f_push[0] = 1'b1;
        f_mosi[1] = 8'hCD; f_tx[1] = 8'h34; f_push[1] = 1'b1;
        run_frame(1'b0, 1'b0, 2);

        // Reset in the middle of a word
        push_tx(8'hE7);
        frame_begin(1'b0, 1'b0);
        void'(model_next_tx());
        xfer(1'b0, 1'b0, 8'h55, 3, got);
        areset = 1'b1;
        cs     = 1'b1;
        @(negedge pclk);
        chk("rst_miso",      {31'd0, miso},      32'd0);
        chk("rst_miso_oe",   {31'd0, miso_oe},   32'd0);
        chk("rst_tx_ready",  {31'd0, tx_ready},  32'd1);
        chk("rst_rx_data",   {24'd0, rx_data},   32'd0);
        chk("rst_mon_mosi",  {24'd0, mon_mosi},  32'd0);
        chk("rst_mon_miso",  {24'd0, mon_miso},  32'd0);
        chk("rst_rx_valid",  {31'd0, rx_valid},  32'd0);
        chk("rst_underrun",  {31'd0, underrun},  32'd0);
        chk("rst_frame_err", {31'd0, frame_err}, 32'd0);
        wait_cyc(2);
        areset = 1'b0;
        wait_cyc(4);
        f_mosi[0] = 8'h7E; f_tx[0] = 8'h81; f_push[0] = 1'b1;
        run_frame(1'b0, 1'b0, 1);

        // Randomized frames: random mode, 1-3 words, occasional missing data
        for (int f = 0; f < 12; f++) begin
            logic cp, ch;
            int   nw;
            cp = 1'($urandom_range(0, 1));
            ch = 1'($urandom_range(0, 1));
            nw = int'($urandom_range(1, 3));
            for (int k = 0; k < 3; k++) begin
                f_mosi[k] = 8'($urandom);
                f_tx[k]   = 8'($urandom);
                f_push[k] = ($urandom_range(0, 3) != 0);
            end
            run_frame(cp, ch, nw);
        end

        wait_cyc(10);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        chk("frame_err_drained",  32'(err_q.size()), 32'd0);
        chk("underrun_total",     seen_underruns, exp_underruns);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/spi_slave_core.md
# spi_slave_core

Synthesizable SPI slave engine that provides the DUT-side behaviour of the slave driver and slave monitor BFMs in one block. It oversamples the SPI pins (`sclk`, `cs`, `mosi`) on the system clock and drives `miso`. It exchanges parallel words with a local transmit/receive interface and publishes a monitor record (MOSI and MISO words) for each completed transfer. It sits between the `spi_if` pins and the slave-side agent/scoreboard logic.

## Interface
- Clock/reset: one clock `pclk`. Reset `areset` is synchronous and active-high. All state changes occur on the rising edge of `pclk`.
- Parameter `DATA_WIDTH`, default 8: bits per SPI word.
- Parameter `MSB_FIRST`, default 1: 1 shifts MSB first, 0 shifts LSB first.
- `pclk` in 1: system clock; must run at ≥4× the `sclk` frequency.
- `areset` in 1: synchronous active-high reset.
- `cpol` in 1: SPI clock idle level; sampled only while `cs` is high.
- `cpha` in 1: 0 samples on the leading edge, 1 samples on the trailing edge.
- `sclk` in 1: SPI clock, asynchronous to `pclk`.
- `cs` in 1: active-low chip select, asynchronous.
- `mosi` in 1: master-out data, asynchronous.
- `miso` out 1: slave-out data.
- `miso_oe` out 1: high while selected (tri-state enable).
- `tx_data` in DATA_WIDTH: next word to transmit.
- `tx_valid` in 1 / `tx_ready` out 1: transmit handshake; a word is taken when both are high.
- `rx_data` out DATA_WIDTH: last received MOSI word.
- `rx_valid` out 1: one-cycle pulse when `rx_data` is updated.
- `mon_mosi`, `mon_miso` out DATA_WIDTH: monitor record for the completed word.
- `mon_valid` out 1: one-cycle pulse, asserted in the same cycle as `rx_valid`.
- `underrun` out 1: one-cycle pulse when a word load finds no `tx_valid`.
- `frame_err` out 1: one-cycle pulse when `cs` rises mid-word.
- `err_bits` out $clog2(DATA_WIDTH+1): number of bits received before the abort; valid with `frame_err`.

## Operation
- Input synchronizer: `sclk`, `cs` and `mosi` each pass through 2-flop synchronizers, followed by one history flop used for edge detection.
- Leading edge of `sclk`: rising when `cpol`=0, falling when `cpol`=1. Trailing edge is the opposite transition.
- States:
  - IDLE: `cs` high. `miso_oe`=0, `miso`=0, `tx_ready`=1.
  - LOAD: one cycle after `cs` falls. Holding register → shift register. If the holding register is empty, load all-ones and pulse `underrun`.
  - SHIFT: active transfer.
- In SHIFT with `cpha`=0:
  - The first bit is on `miso` from LOAD onward.
  - Sample `mosi` on each leading edge; advance `miso` on each trailing edge.
- In SHIFT with `cpha`=1:
  - Advance `miso` on each leading edge (the first leading edge presents bit 0).
  - Sample `mosi` on each trailing edge.
- Word complete (DATA_WIDTH samples):
  - Pulse `rx_valid` and `mon_valid`. Set `rx_data` = `mon_mosi` = received word and `mon_miso` = transmitted word.
  - Bit counter clears.
  - The next word loads immediately from the holding register, so back-to-back words need no `cs` toggle.
- Holding register: one entry.
  - `tx_ready`=1 when the entry is empty.
  - A load into the shift register empties the entry.
  - The `tx_valid` handshake and a load in the same cycle are both honoured.
- `cs` rises during SHIFT:
  - If the bit count is nonzero, pulse `frame_err` with `err_bits` = count; no `rx_valid`.
  - Return to IDLE.
  - The holding register is kept.
- `cpol`/`cpha` changes while selected are ignored; the values latched in LOAD are used.

## Timing
- Reset values:
  - `miso`=0, `miso_oe`=0, `tx_ready`=1.
  - `rx_data`, `mon_mosi`, `mon_miso` = 0.
  - All pulses 0.
  - Holding register empty; state IDLE.
- Reset mid-frame aborts with no `frame_err`.
- Pin-to-action latency: a pin edge becomes effective exactly 3 `pclk` cycles later (2 synchronizer stages plus 1 register update). Examples:
  - `rx_valid` asserts 3 cycles after the final sampling `sclk` edge.
  - `miso` changes 3 cycles after its shift edge.
- `cs` falling → `miso_oe`=1 and first bit valid after 3 cycles. Master's first edge must follow at least 4 `pclk` cycles later.
- `sclk` high and low phases must each be ≥2 `pclk` cycles.
- Simultaneous `cs` rise and final sampling edge: the word completes (`rx_valid`) and no `frame_err`.

## Structure
- Package `spi_pkg`:
  - `spi_state_e` (IDLE, LOAD, SHIFT).
  - `spi_mode_t` struct {`cpol`, `cpha`}.
  - Default DATA_WIDTH constant.
- Sub-module `spi_pin_sync`: 2-flop synchronizer plus edge detector; instantiated for `sclk`, `cs` and `mosi`. Provides rise/fall strobes and synchronized levels.

## Test plan
- Mode 0, `tx_data`=0xA5 preloaded, master sends 0x3C → `rx_data`=0x3C, master receives 0xA5, `mon_mosi`=0x3C / `mon_miso`=0xA5 with `mon_valid`.
- Mode 3 (`cpol`=1, `cpha`=1), `tx_data`=0x5A, master sends 0xC3 → `rx_data`=0xC3, master receives 0x5A.
- No `tx_valid` before `cs` falls → master receives 0xFF, `underrun` pulses once.
- `cs` rises after 5 `sclk` cycles → `frame_err` with `err_bits`=5, no `rx_valid`, `miso_oe`=0 within 3 cycles.
- Back-to-back words, tx 0x12 then 0x34, master sends 0xAB then 0xCD with `cs` held low → two `rx_valid` pulses (0xAB, 0xCD), master receives 0x12, 0x34.
- `areset` asserted mid-word → next cycle all outputs at reset values. A subsequent full frame with tx 0x81 / master 0x7E transfers correctly.
